// File: rtl/bc_datapath_if.sv
// Controller <-> datapath bundle for the basic computer: bus select, packed
// control vector, and the register values the controller and observers need.
interface bc_datapath_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_W     = 12,
    parameter int CTRL_LNGTH = 21
);
    logic [2:0]              BUS_SEL;
    logic [3*CTRL_LNGTH-1:0] CTRL;
    logic [WIDTH-1:0]        IR;
    logic [WIDTH-1:0]        AC;
    logic                    E;
    logic [ADDR_W-1:0]       AR;
    logic [ADDR_W-1:0]       PC;
    logic [WIDTH-1:0]        BUS;

    modport master (
        output BUS_SEL, CTRL,
        input  IR, AC, E, AR, PC, BUS
    );

    modport slave (
        input  BUS_SEL, CTRL,
        output IR, AC, E, AR, PC, BUS
    );
endinterface

// File: rtl/bc_datapath.sv
// Basic-computer register-transfer datapath: common bus, AR/PC/DR/AC/IR/TR/E,
// ALU and word memory, all slaved cycle-by-cycle to the controller's vector.
module bc_datapath #(
    parameter int WIDTH      = 16,
    parameter int ADDR_W     = 12,
    parameter int CTRL_LNGTH = 21
) (
    input  logic         clk,
    input  logic         rst,
    bc_datapath_if.slave dp
);
    localparam int AR_LD  = 0;
    localparam int AR_INR = 1;
    localparam int AR_CLR = 2;
    localparam int PC_LD  = 3;
    localparam int IR_LD  = 4;
    localparam int DR_LD  = 5;
    localparam int DR_INR = 6;
    localparam int TR_LD  = 7;
    localparam int MEM_WR = 8;
    localparam int AC_LD  = 9;
    localparam int AC_INR = 10;
    localparam int AC_CLR = 11;
    localparam int PC_INR = 12;
    localparam int PC_CLR = 13;
    localparam int TR_INR = 14;
    localparam int DR_CLR = 15;
    localparam int TR_CLR = 16;
    localparam int E_LD   = 17;
    localparam int E_CMP  = 18;
    localparam int E_CLR  = 19;
    localparam int ALU_OP = 20;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_LDA  = 3'b010;
    localparam logic [2:0] OP_CMA  = 3'b011;
    localparam logic [2:0] OP_CIL  = 3'b100;
    localparam logic [2:0] OP_CIR  = 3'b101;
    localparam logic [2:0] OP_INP  = 3'b110;

    localparam logic [2:0] SEL_ZERO = 3'b000;
    localparam logic [2:0] SEL_PC   = 3'b001;
    localparam logic [2:0] SEL_DR   = 3'b010;
    localparam logic [2:0] SEL_AC   = 3'b011;
    localparam logic [2:0] SEL_IR   = 3'b100;
    localparam logic [2:0] SEL_TR   = 3'b101;
    localparam logic [2:0] SEL_MEM  = 3'b110;

    localparam int DEPTH = 2 ** ADDR_W;

    // Single-bit entries only look at bit 3i; the upper two bits are ignored.
    logic [CTRL_LNGTH-2:0]       ctl;
    logic [2*(CTRL_LNGTH-1)-1:0] unused_ctrl_hi;
    logic [2:0]                  alu_op;

    genvar gi;
    generate
        for (gi = 0; gi < CTRL_LNGTH - 1; gi++) begin : g_ctrl
            assign ctl[gi]                   = dp.CTRL[3*gi];
            assign unused_ctrl_hi[2*gi +: 2] = dp.CTRL[3*gi+1 +: 2];
        end
    endgenerate

    assign alu_op = dp.CTRL[3*ALU_OP +: 3];

    logic [ADDR_W-1:0] ar_q, ar_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]  dr_q, dr_d;
    logic [WIDTH-1:0]  ac_q, ac_d;
    logic [WIDTH-1:0]  ir_q, ir_d;
    logic [WIDTH-1:0]  tr_q, tr_d;
    logic              e_q, e_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_rd;
    logic [WIDTH-1:0]  bus;

    assign mem_rd = mem_q[ar_q];

    // Common bus: 12-bit sources are zero-extended to the full width.
    always_comb begin
        bus = '0;
        case (dp.BUS_SEL)
            SEL_ZERO: bus = '0;
            SEL_PC:   bus = {{(WIDTH-ADDR_W){1'b0}}, pc_q};
            SEL_DR:   bus = dr_q;
            SEL_AC:   bus = ac_q;
            SEL_IR:   bus = ir_q;
            SEL_TR:   bus = tr_q;
            SEL_MEM:  bus = mem_rd;
            default:  bus = {{(WIDTH-ADDR_W){1'b0}}, ar_q};
        endcase
    end

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_e;
    logic             alu_e_wr;

    assign add_sum = {1'b0, ac_q} + {1'b0, dr_q};

    always_comb begin
        alu_res  = ac_q;
        alu_e    = e_q;
        alu_e_wr = 1'b0;
        case (alu_op)
            OP_AND: alu_res = ac_q & dr_q;
            OP_ADD: begin
                alu_res  = add_sum[WIDTH-1:0];
                alu_e    = add_sum[WIDTH];
                alu_e_wr = 1'b1;
            end
            OP_LDA: alu_res = dr_q;
            OP_CMA: alu_res = ~ac_q;
            OP_CIL: begin
                alu_res  = {ac_q[WIDTH-2:0], e_q};
                alu_e    = ac_q[WIDTH-1];
                alu_e_wr = 1'b1;
            end
            OP_CIR: begin
                alu_res  = {e_q, ac_q[WIDTH-1:1]};
                alu_e    = ac_q[0];
                alu_e_wr = 1'b1;
            end
            OP_INP:  alu_res = bus;
            default: alu_res = ac_q;
        endcase
    end

    // Every register resolves CLR > LD > INR; all loads see the pre-edge bus.
    always_comb begin
        ar_d = ar_q;
        if (ctl[AR_CLR])      ar_d = '0;
        else if (ctl[AR_LD])  ar_d = bus[ADDR_W-1:0];
        else if (ctl[AR_INR]) ar_d = ar_q + ADDR_W'(1);

        pc_d = pc_q;
        if (ctl[PC_CLR])      pc_d = '0;
        else if (ctl[PC_LD])  pc_d = bus[ADDR_W-1:0];
        else if (ctl[PC_INR]) pc_d = pc_q + ADDR_W'(1);

        dr_d = dr_q;
        if (ctl[DR_CLR])      dr_d = '0;
        else if (ctl[DR_LD])  dr_d = bus;
        else if (ctl[DR_INR]) dr_d = dr_q + WIDTH'(1);

        tr_d = tr_q;
        if (ctl[TR_CLR])      tr_d = '0;
        else if (ctl[TR_LD])  tr_d = bus;
        else if (ctl[TR_INR]) tr_d = tr_q + WIDTH'(1);

        ac_d = ac_q;
        if (ctl[AC_CLR])      ac_d = '0;
        else if (ctl[AC_LD])  ac_d = alu_res;
        else if (ctl[AC_INR]) ac_d = ac_q + WIDTH'(1);

        ir_d = ir_q;
        if (ctl[IR_LD])       ir_d = bus;

        e_d = e_q;
        if (ctl[E_CLR])                    e_d = 1'b0;
        else if (ctl[E_CMP])               e_d = ~e_q;
        else if (ctl[AC_LD] && alu_e_wr)   e_d = alu_e;
        else if (ctl[E_LD])                e_d = bus[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_q <= '0;
            pc_q <= '0;
            dr_q <= '0;
            ac_q <= '0;
            ir_q <= '0;
            tr_q <= '0;
            e_q  <= 1'b0;
        end else begin
            ar_q <= ar_d;
            pc_q <= pc_d;
            dr_q <= dr_d;
            ac_q <= ac_d;
            ir_q <= ir_d;
            tr_q <= tr_d;
            e_q  <= e_d;
        end
    end

    // Memory is never cleared; reset only suppresses a write in flight.
    always_ff @(posedge clk) begin
        if (!rst && ctl[MEM_WR]) begin
            mem_q[ar_q] <= bus;
        end
    end

    assign dp.IR  = ir_q;
    assign dp.AC  = ac_q;
    assign dp.E   = e_q;
    assign dp.AR  = ar_q;
    assign dp.PC  = pc_q;
    assign dp.BUS = bus;
endmodule

// File: tb/tb_bc_datapath.sv
// Self-checking bench for bc_datapath: directed micro-operation scenarios plus
// randomized control vectors compared against an arithmetic reference model.
module tb_bc_datapath;
    localparam int WIDTH      = 16;
    localparam int ADDR_W     = 12;
    localparam int CTRL_LNGTH = 21;

    localparam logic [19:0] M_AR_LD  = 20'd1 << 0;
    localparam logic [19:0] M_AR_INR = 20'd1 << 1;
    localparam logic [19:0] M_AR_CLR = 20'd1 << 2;
    localparam logic [19:0] M_PC_LD  = 20'd1 << 3;
    localparam logic [19:0] M_IR_LD  = 20'd1 << 4;
    localparam logic [19:0] M_DR_LD  = 20'd1 << 5;
    localparam logic [19:0] M_DR_INR = 20'd1 << 6;
    localparam logic [19:0] M_TR_LD  = 20'd1 << 7;
    localparam logic [19:0] M_MEM_WR = 20'd1 << 8;
    localparam logic [19:0] M_AC_LD  = 20'd1 << 9;
    localparam logic [19:0] M_AC_INR = 20'd1 << 10;
    localparam logic [19:0] M_AC_CLR = 20'd1 << 11;
    localparam logic [19:0] M_PC_INR = 20'd1 << 12;
    localparam logic [19:0] M_PC_CLR = 20'd1 << 13;
    localparam logic [19:0] M_TR_INR = 20'd1 << 14;
    localparam logic [19:0] M_DR_CLR = 20'd1 << 15;
    localparam logic [19:0] M_TR_CLR = 20'd1 << 16;
    localparam logic [19:0] M_E_LD   = 20'd1 << 17;
    localparam logic [19:0] M_E_CMP  = 20'd1 << 18;
    localparam logic [19:0] M_E_CLR  = 20'd1 << 19;

    localparam logic [2:0] OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_CMA = 3'd3;
    localparam logic [2:0] OP_CIL = 3'd4, OP_CIR = 3'd5, OP_INP = 3'd6, OP_HOLD = 3'd7;
    localparam logic [2:0] S_NONE = 3'd0, S_PC = 3'd1, S_DR = 3'd2, S_AC = 3'd3;
    localparam logic [2:0] S_IR = 3'd4, S_TR = 3'd5, S_MEM = 3'd6, S_AR = 3'd7;

    logic clk;
    logic rst;

    bc_datapath_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CTRL_LNGTH(CTRL_LNGTH)) dp_if ();

    bc_datapath #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CTRL_LNGTH(CTRL_LNGTH)) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: plain integers, memory as an integer array.
    int unsigned m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_e, m_bus;
    int unsigned m_mem [4096];
    logic [15:0] pre_bus;

    function automatic logic [62:0] mkctrl(input logic [19:0] m, input logic [2:0] op,
                                           input logic [39:0] junk);
        logic [62:0] v;
        v = '0;
        for (int i = 0; i < 20; i++) begin
            v[3*i]   = m[i];
            v[3*i+1] = junk[2*i];
            v[3*i+2] = junk[2*i+1];
        end
        v[62:60] = op;
        return v;
    endfunction

    task automatic model_step(input logic r, input logic [2:0] sel, input logic [19:0] m,
                              input logic [2:0] op);
        int unsigned bus, alu, alu_e, sum;
        int unsigned n_ar, n_pc, n_dr, n_ac, n_ir, n_tr, n_e;
        bit writes_e;
        case (sel)
            S_NONE:  bus = 0;
            S_PC:    bus = m_pc;
            S_DR:    bus = m_dr;
            S_AC:    bus = m_ac;
            S_IR:    bus = m_ir;
            S_TR:    bus = m_tr;
            S_MEM:   bus = m_mem[m_ar];
            default: bus = m_ar;
        endcase
        m_bus = bus;
        if (r) begin
            m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_tr = 0; m_e = 0;
            return;
        end
        alu_e = m_e;
        writes_e = 0;
        case (op)
            OP_AND: alu = m_ac & m_dr;
            OP_ADD: begin sum = m_ac + m_dr; alu = sum % 65536; alu_e = sum / 65536; writes_e = 1; end
            OP_LDA: alu = m_dr;
            OP_CMA: alu = 65535 - m_ac;
            OP_CIL: begin alu = (m_ac * 2) % 65536 + m_e; alu_e = m_ac / 32768; writes_e = 1; end
            OP_CIR: begin alu = m_e * 32768 + m_ac / 2; alu_e = m_ac % 2; writes_e = 1; end
            OP_INP: alu = bus;
            default: alu = m_ac;
        endcase
        n_ar = (m & M_AR_CLR) != 0 ? 0 : (m & M_AR_LD) != 0 ? bus % 4096 :
               (m & M_AR_INR) != 0 ? (m_ar + 1) % 4096 : m_ar;
        n_pc = (m & M_PC_CLR) != 0 ? 0 : (m & M_PC_LD) != 0 ? bus % 4096 :
               (m & M_PC_INR) != 0 ? (m_pc + 1) % 4096 : m_pc;
        n_dr = (m & M_DR_CLR) != 0 ? 0 : (m & M_DR_LD) != 0 ? bus :
               (m & M_DR_INR) != 0 ? (m_dr + 1) % 65536 : m_dr;
        n_tr = (m & M_TR_CLR) != 0 ? 0 : (m & M_TR_LD) != 0 ? bus :
               (m & M_TR_INR) != 0 ? (m_tr + 1) % 65536 : m_tr;
        n_ac = (m & M_AC_CLR) != 0 ? 0 : (m & M_AC_LD) != 0 ? alu :
               (m & M_AC_INR) != 0 ? (m_ac + 1) % 65536 : m_ac;
        n_ir = (m & M_IR_LD) != 0 ? bus : m_ir;
        n_e  = (m & M_E_CLR) != 0 ? 0 : (m & M_E_CMP) != 0 ? 1 - m_e :
               ((m & M_AC_LD) != 0 && writes_e) ? alu_e : (m & M_E_LD) != 0 ? bus % 2 : m_e;
        if ((m & M_MEM_WR) != 0) m_mem[m_ar] = bus;
        m_ar = n_ar; m_pc = n_pc; m_dr = n_dr; m_ac = n_ac; m_ir = n_ir; m_tr = n_tr; m_e = n_e;
    endtask

    // One clock of stimulus: drive, capture pre-edge bus, step model, clock.
    task automatic cycle(input logic r, input logic [2:0] sel, input logic [19:0] m,
                         input logic [2:0] op, input logic [39:0] junk);
        rst = r;
        dp_if.BUS_SEL = sel;
        dp_if.CTRL = mkctrl(m, op, junk);
        #2;
        pre_bus = dp_if.BUS;
        model_step(r, sel, m, op);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] sel, input logic [19:0] m, input logic [2:0] aop);
        cycle(1'b0, sel, m, aop, 40'd0);
    endtask

    // Builds any AC value by shifting in zeros and incrementing set bits.
    task automatic load_ac(input logic [15:0] v);
        op(S_NONE, M_AC_CLR | M_E_CLR, OP_HOLD);
        for (int b = 15; b >= 0; b--) begin
            op(S_NONE, M_AC_LD | M_E_CLR, OP_CIL);
            if (v[b]) op(S_NONE, M_AC_INR, OP_HOLD);
        end
    endtask

    task automatic test_reset;
        cycle(1'b1, S_NONE, 20'd0, OP_HOLD, 40'd0);
        checks++; if (dp_if.AR !== 12'h000) begin failures++; $display("FAIL reset_ar actual=%h expected=000", dp_if.AR); end
        checks++; if (dp_if.PC !== 12'h000) begin failures++; $display("FAIL reset_pc actual=%h expected=000", dp_if.PC); end
        checks++; if (dp_if.AC !== 16'h0000) begin failures++; $display("FAIL reset_ac actual=%h expected=0000", dp_if.AC); end
        checks++; if (dp_if.IR !== 16'h0000) begin failures++; $display("FAIL reset_ir actual=%h expected=0000", dp_if.IR); end
        checks++; if (dp_if.E !== 1'b0) begin failures++; $display("FAIL reset_e actual=%b expected=0", dp_if.E); end
        dp_if.BUS_SEL = S_DR; #1;
        checks++; if (dp_if.BUS !== 16'h0000) begin failures++; $display("FAIL reset_dr actual=%h expected=0000", dp_if.BUS); end
        dp_if.BUS_SEL = S_TR; #1;
        checks++; if (dp_if.BUS !== 16'h0000) begin failures++; $display("FAIL reset_tr actual=%h expected=0000", dp_if.BUS); end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_fetch;
        load_ac(16'h7800);
        op(S_AC, M_MEM_WR, OP_HOLD);
        op(S_PC, M_AR_LD, OP_HOLD);
        checks++; if (dp_if.AR !== 12'h000) begin failures++; $display("FAIL fetch_t0_ar actual=%h expected=000", dp_if.AR); end
        op(S_MEM, M_IR_LD | M_PC_INR, OP_HOLD);
        checks++; if (pre_bus !== 16'h7800) begin failures++; $display("FAIL fetch_t1_bus actual=%h expected=7800", pre_bus); end
        checks++; if (dp_if.IR !== 16'h7800) begin failures++; $display("FAIL fetch_t1_ir actual=%h expected=7800", dp_if.IR); end
        checks++; if (dp_if.PC !== 12'h001) begin failures++; $display("FAIL fetch_t1_pc actual=%h expected=001", dp_if.PC); end
        op(S_IR, M_AR_LD, OP_HOLD);
        checks++; if (dp_if.AR !== 12'h800) begin failures++; $display("FAIL fetch_t2_ar actual=%h expected=800", dp_if.AR); end
        $display("test_fetch done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back;
        op(S_PC, M_AR_LD | M_PC_INR, OP_HOLD);
        checks++; if (dp_if.AR !== 12'h001) begin failures++; $display("FAIL b2b_ar actual=%h expected=001", dp_if.AR); end
        checks++; if (dp_if.PC !== 12'h002) begin failures++; $display("FAIL b2b_pc actual=%h expected=002", dp_if.PC); end
        $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_cma;
        load_ac(16'h00F0);
        op(S_NONE, M_E_CMP, OP_HOLD);
        op(S_NONE, M_AC_LD, OP_CMA);
        checks++; if (dp_if.AC !== 16'hFF0F) begin failures++; $display("FAIL cma_ac actual=%h expected=ff0f", dp_if.AC); end
        checks++; if (dp_if.E !== 1'b1) begin failures++; $display("FAIL cma_e actual=%b expected=1", dp_if.E); end
        $display("test_cma done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_cil_cir;
        load_ac(16'h8001);
        op(S_NONE, M_AC_LD, OP_CIL);
        checks++; if (dp_if.AC !== 16'h0002) begin failures++; $display("FAIL cil_ac actual=%h expected=0002", dp_if.AC); end
        checks++; if (dp_if.E !== 1'b1) begin failures++; $display("FAIL cil_e actual=%b expected=1", dp_if.E); end
        op(S_NONE, M_AC_LD, OP_CIR);
        checks++; if (dp_if.AC !== 16'h8001) begin failures++; $display("FAIL cir_ac actual=%h expected=8001", dp_if.AC); end
        checks++; if (dp_if.E !== 1'b0) begin failures++; $display("FAIL cir_e actual=%b expected=0", dp_if.E); end
        $display("test_cil_cir done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_add_carry;
        load_ac(16'h0002);
        op(S_AC, M_DR_LD, OP_HOLD);
        load_ac(16'hFFFF);
        op(S_NONE, M_AC_LD, OP_ADD);
        checks++; if (dp_if.AC !== 16'h0001) begin failures++; $display("FAIL add_ac actual=%h expected=0001", dp_if.AC); end
        checks++; if (dp_if.E !== 1'b1) begin failures++; $display("FAIL add_e actual=%b expected=1", dp_if.E); end
        load_ac(16'hFFFF);
        op(S_NONE, M_E_CMP, OP_HOLD);
        op(S_NONE, M_AC_INR, OP_HOLD);
        checks++; if (dp_if.AC !== 16'h0000) begin failures++; $display("FAIL inr_wrap_ac actual=%h expected=0000", dp_if.AC); end
        checks++; if (dp_if.E !== 1'b1) begin failures++; $display("FAIL inr_wrap_e actual=%b expected=1", dp_if.E); end
        $display("test_add_carry done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_priority_wrap;
        load_ac(16'h0FFF);
        op(S_AC, M_PC_LD, OP_HOLD);
        op(S_NONE, M_PC_INR, OP_HOLD);
        checks++; if (dp_if.PC !== 12'h000) begin failures++; $display("FAIL pc_wrap actual=%h expected=000", dp_if.PC); end
        op(S_AC, M_PC_LD | M_PC_INR, OP_HOLD);
        checks++; if (dp_if.PC !== 12'hFFF) begin failures++; $display("FAIL pc_ld_over_inr actual=%h expected=fff", dp_if.PC); end
        op(S_AC, M_AR_CLR | M_AR_LD | M_AR_INR, OP_HOLD);
        checks++; if (dp_if.AR !== 12'h000) begin failures++; $display("FAIL ar_clr_first actual=%h expected=000", dp_if.AR); end
        load_ac(16'h1234);
        op(S_AC, M_DR_LD, OP_HOLD);
        op(S_NONE, M_AC_CLR | M_AC_LD, OP_LDA);
        checks++; if (dp_if.AC !== 16'h0000) begin failures++; $display("FAIL ac_clr_over_ld actual=%h expected=0000", dp_if.AC); end
        op(S_NONE, M_E_CMP, OP_HOLD);
        op(S_NONE, M_E_CLR | M_E_CMP, OP_HOLD);
        checks++; if (dp_if.E !== 1'b0) begin failures++; $display("FAIL e_clr_over_cmp actual=%b expected=0", dp_if.E); end
        $display("test_priority_wrap done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid_op;
        load_ac(16'h0234);
        op(S_AC, M_AR_LD, OP_HOLD);
        load_ac(16'h5A5A);
        op(S_AC, M_MEM_WR, OP_HOLD);
        load_ac(16'h1234);
        cycle(1'b1, S_AC, M_MEM_WR | M_AC_INR | M_PC_INR, OP_HOLD, 40'd0);
        checks++; if (dp_if.AC !== 16'h0000) begin failures++; $display("FAIL rstmid_ac actual=%h expected=0000", dp_if.AC); end
        checks++; if (dp_if.PC !== 12'h000) begin failures++; $display("FAIL rstmid_pc actual=%h expected=000", dp_if.PC); end
        checks++; if (dp_if.AR !== 12'h000) begin failures++; $display("FAIL rstmid_ar actual=%h expected=000", dp_if.AR); end
        load_ac(16'h0234);
        op(S_AC, M_AR_LD, OP_HOLD);
        dp_if.BUS_SEL = S_MEM; #1;
        checks++; if (dp_if.BUS !== 16'h5A5A) begin failures++; $display("FAIL rstmid_mem actual=%h expected=5a5a", dp_if.BUS); end
        $display("test_reset_mid_op done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_random;
        logic [19:0] m;
        logic [2:0]  sel, aop;
        logic [39:0] junk;
        logic        r;
        // Fill every memory word so random M[AR] reads are known to the model.
        for (int i = 0; i < 4096; i++) op(S_AC, M_MEM_WR | M_AR_INR | M_AC_INR, OP_HOLD);
        for (int i = 0; i < 3000; i++) begin
            m    = 20'($urandom & $urandom);
            sel  = 3'($urandom_range(0, 7));
            aop  = 3'($urandom_range(0, 7));
            junk = {8'($urandom), 32'($urandom)};
            r    = ($urandom_range(0, 63) == 0);
            cycle(r, sel, m, aop, junk);
            checks++; if (pre_bus !== 16'(m_bus)) begin failures++; $display("FAIL rnd_bus cyc=%0d actual=%h expected=%h", i, pre_bus, 16'(m_bus)); end
            checks++; if (dp_if.AC !== 16'(m_ac)) begin failures++; $display("FAIL rnd_ac cyc=%0d actual=%h expected=%h", i, dp_if.AC, 16'(m_ac)); end
            checks++; if (dp_if.E !== 1'(m_e)) begin failures++; $display("FAIL rnd_e cyc=%0d actual=%b expected=%b", i, dp_if.E, 1'(m_e)); end
            checks++; if (dp_if.AR !== 12'(m_ar)) begin failures++; $display("FAIL rnd_ar cyc=%0d actual=%h expected=%h", i, dp_if.AR, 12'(m_ar)); end
            checks++; if (dp_if.PC !== 12'(m_pc)) begin failures++; $display("FAIL rnd_pc cyc=%0d actual=%h expected=%h", i, dp_if.PC, 12'(m_pc)); end
            checks++; if (dp_if.IR !== 16'(m_ir)) begin failures++; $display("FAIL rnd_ir cyc=%0d actual=%h expected=%h", i, dp_if.IR, 16'(m_ir)); end
        end
        $display("test_random done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        rst = 1'b1;
        dp_if.BUS_SEL = S_NONE;
        dp_if.CTRL = mkctrl(20'd0, OP_HOLD, 40'd0);
        m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_tr = 0; m_e = 0; m_bus = 0;
        pre_bus = '0;
        test_reset;
        test_fetch;
        test_back_to_back;
        test_cma;
        test_cil_cir;
        test_add_carry;
        test_priority_wrap;
        test_reset_mid_op;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bc_datapath.md
Name: bc_datapath

Overview:
- Register-transfer datapath for the basic computer. It is the responder to the controller.
- Each clock it consumes the controller's BUS_SEL and control-signal vector and performs the selected transfers on a shared 16-bit common bus.
- It holds AR, PC, DR, AC, IR, TR, the E flag, the ALU and a 4096x16 word memory.
- It returns IR to the controller for decoding.

Parameters:
WIDTH, 16, data/bus width
ADDR_W, 12, address width of AR/PC and memory depth 2**ADDR_W
CTRL_LNGTH, 21, number of 3-bit control entries

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
BUS_SEL  input  3  common-bus source select
CTRL  input  3*CTRL_LNGTH  packed control vector; entry i = CTRL[3i+2:3i]; 1-bit entries use bit 3i only
IR  output  WIDTH  instruction register, to controller
AC  output  WIDTH  accumulator
E  output  1  extend/carry flag
AR  output  ADDR_W  address register (observability)
PC  output  ADDR_W  program counter (observability)
BUS  output  WIDTH  current common-bus value (observability)

Behaviour:
- Reset: rst high at an edge sets AR, PC, DR, AC, IR, TR and E to 0. Memory contents are not reset. rst overrides every control entry, including MEM_WR.
- BUS_SEL encoding (combinational mux):
  - 000 -> 0
  - 001 -> PC
  - 010 -> DR
  - 011 -> AC
  - 100 -> IR
  - 101 -> TR
  - 110 -> M[AR]
  - 111 -> AR
  - 12-bit sources are zero-extended to WIDTH.
- Memory read is combinational. Write is on the clock edge: M[AR] <= BUS when MEM_WR=1.
- Control entry map:
  - 0 AR_LD, 1 AR_INR, 2 AR_CLR
  - 3 PC_LD, 12 PC_INR, 13 PC_CLR
  - 4 IR_LD
  - 5 DR_LD, 6 DR_INR, 15 DR_CLR
  - 7 TR_LD, 14 TR_INR, 16 TR_CLR
  - 8 MEM_WR
  - 9 AC_LD, 10 AC_INR, 11 AC_CLR
  - 17 E_LD, 18 E_CMP, 19 E_CLR
  - 20 ALU_OP (3 bits)
  - Idle vector: all entries 000 except ALU_OP=111.
- Register update priority per register: CLR > LD > INR. LD on a 12-bit register takes BUS[ADDR_W-1:0]. INR wraps modulo 2**width (PC 0xFFF+1 -> 0x000; AC 0xFFFF+1 -> 0x0000, E unchanged).
- All loads in one cycle sample the bus as driven by pre-edge register values. Example: AR_LD with BUS_SEL=PC, plus PC_INR in the same cycle, gives AR = old PC.
- ALU operates on AC, DR and E. The result loads into AC only when AC_LD=1.
  - 000 AND: AC & DR
  - 001 ADD: AC + DR; E <= carry out
  - 010 LDA: DR
  - 011 CMA: ~AC
  - 100 CIL: {AC[14:0], E}; E <= AC[15]
  - 101 CIR: {E, AC[15:1]}; E <= AC[0]
  - 110 INP: BUS
  - 111 hold: AC
  - E is written by ALU ops 001/100/101 only when AC_LD=1.
- E priority: E_CLR > E_CMP > ALU carry/shift > E_LD (E <= BUS[0]).
- No handshake. The block is fully slave to the controller, with single-cycle latency for every micro-operation.
- Reset asserted mid-instruction discards any pending write in that cycle. The first post-reset cycle behaves as a fresh fetch with PC=0.

Test Plan:
- Fetch: M[0]=0x7800. Apply T0 (BUS_SEL=001, AR_LD), T1 (BUS_SEL=110, IR_LD, PC_INR), T2 (BUS_SEL=100, AR_LD) -> AR=0, IR=0x7800, PC=1, then AR=0x800.
- CMA: AC=0x00F0. Apply AC_LD, ALU_OP=011 -> AC=0xFF0F, E unchanged.
- CIL/CIR: AC=0x8001, E=0. CIL -> AC=0x0002, E=1. Then CIR -> AC=0x8001, E=0.
- ADD carry: AC=0xFFFF, DR=0x0002. Apply ADD with AC_LD -> AC=0x0001, E=1. AC_INR on 0xFFFF -> 0x0000.
- Priority/wrap: PC=0xFFF with PC_INR -> 0x000. AC_CLR+AC_LD same cycle -> AC=0. E_CLR+E_CMP -> E=0.
- Reset mid-op: rst=1 with MEM_WR=1, BUS_SEL=011, AC=0x1234 -> M[AR] unchanged, all registers 0 next cycle.
